// File: rtl/hint_bit_pack.sv
// hint_bit_pack: ML-DSA HintBitPack encoder.
// Scans the K x N hint matrix one coefficient per clock and builds the
// OMEGA index bytes followed by K cumulative-count bytes (tail of sigma).
// Optional feature macro: HINT_PACK_STREAM_EN adds a byte-stream output
// (byte_out/byte_valid/byte_ready) that drains y after the scan.
//
// Handshake (stream build only): a byte moves on a rising edge where
// byte_valid && byte_ready are both high; while byte_valid is high and
// byte_ready is low, byte_out holds its value; byte_valid never drops
// without a transfer.
module hint_bit_pack #(
  parameter int K     = 8,
  parameter int N     = 256,
  parameter int OMEGA = 75
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [K*N-1:0]           h_in,
  output logic [(OMEGA+K)*8-1:0]   y,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow
`ifdef HINT_PACK_STREAM_EN
  ,
  output logic [7:0]               byte_out,
  output logic                     byte_valid,
  input  logic                     byte_ready
`endif
);

  localparam int KN = K * N;
  localparam int YB = OMEGA + K;
  localparam int YW = YB * 8;
  localparam int IW = $clog2(OMEGA + 1);
  localparam int JW = (N > 1) ? $clog2(N) : 1;
  localparam int KW = (K > 1) ? $clog2(K) : 1;
`ifdef HINT_PACK_STREAM_EN
  localparam int BW = (YB > 1) ? $clog2(YB) : 1;
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCAN   = 2'd1,
    S_DONE   = 2'd2
`ifdef HINT_PACK_STREAM_EN
    ,
    S_STREAM = 2'd3
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [KN-1:0]   h_q, h_d;       // latched hints, shifted so bit 0 is the current coefficient
  logic [YW-1:0]   y_q, y_d;
  logic            ovf_q, ovf_d;
  logic [IW-1:0]   idx_q, idx_d;   // number of index bytes written so far
  logic [KW-1:0]   i_q, i_d;       // polynomial counter
  logic [JW-1:0]   j_q, j_d;       // coefficient counter
  logic [IW-1:0]   idx_nx;         // idx after this cycle's update
`ifdef HINT_PACK_STREAM_EN
  logic [BW-1:0]   bp_q, bp_d;     // next byte of y to stream
`endif

  // State and datapath registers; reset aborts any scan immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      h_q     <= '0;
      y_q     <= '0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
`ifdef HINT_PACK_STREAM_EN
      bp_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      y_q     <= y_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
      i_q     <= i_d;
      j_q     <= j_d;
`ifdef HINT_PACK_STREAM_EN
      bp_q    <= bp_d;
`endif
    end
  end

  // Next-state and datapath update: one coefficient consumed per SCAN cycle.
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    y_d     = y_q;
    ovf_d   = ovf_q;
    idx_d   = idx_q;
    i_d     = i_q;
    j_d     = j_q;
    idx_nx  = idx_q;
`ifdef HINT_PACK_STREAM_EN
    bp_d    = bp_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          h_d     = h_in;
          y_d     = '0;
          ovf_d   = 1'b0;
          idx_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = S_SCAN;
        end
      end

      S_SCAN: begin
        // Shifting keeps the current coefficient at bit 0 and avoids a
        // wide read mux; scan order i*N+j matches ascending bit order.
        h_d = h_q >> 1;
        if (h_q[0]) begin
          if (idx_q < IW'(OMEGA)) begin
            y_d[int'(idx_q)*8 +: 8] = 8'(j_q);
            idx_nx                  = idx_q + IW'(1);
          end else begin
            // Weight limit reached: flag it and drop the index.
            ovf_d = 1'b1;
          end
        end
        idx_d = idx_nx;

        if (j_q == JW'(N - 1)) begin
          // End of polynomial i: record the running count including this cycle.
          y_d[(OMEGA + int'(i_q))*8 +: 8] = 8'(idx_nx);
          j_d = '0;
          if (i_q == KW'(K - 1)) begin
            i_d = '0;
`ifdef HINT_PACK_STREAM_EN
            bp_d    = '0;
            state_d = S_STREAM;
`else
            state_d = S_DONE;
`endif
          end else begin
            i_d = i_q + KW'(1);
          end
        end else begin
          j_d = j_q + JW'(1);
        end
      end

`ifdef HINT_PACK_STREAM_EN
      S_STREAM: begin
        if (byte_ready) begin
          if (bp_q == BW'(YB - 1)) begin
            bp_d    = '0;
            state_d = S_DONE;
          end else begin
            bp_d = bp_q + BW'(1);
          end
        end
      end
`endif

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from registered state only, so done/busy are glitch-free.
  always_comb begin
    y        = y_q;
    overflow = ovf_q;
    done     = (state_q == S_DONE);
    busy     = (state_q == S_SCAN);
`ifdef HINT_PACK_STREAM_EN
    busy       = (state_q == S_SCAN) || (state_q == S_STREAM);
    byte_valid = (state_q == S_STREAM);
    byte_out   = (state_q == S_STREAM) ? y_q[int'(bp_q)*8 +: 8] : 8'd0;
`endif
  end

endmodule

// File: tb/tb_hint_bit_pack.sv
// tb_hint_bit_pack: self-checking bench for hint_bit_pack.
// Expected results come from a behavioural model pushed into a queue at
// start and popped when the DUT pulses done. Stream build: HINT_PACK_STREAM_EN.
module tb_hint_bit_pack;

  localparam int K      = 8;
  localparam int N      = 256;
  localparam int OMEGA  = 75;
  localparam int KN     = K * N;
  localparam int YB     = OMEGA + K;
  localparam int YW     = YB * 8;
  localparam int LAT    = KN + 1;
  localparam int BUDGET = 4000;

  // Clock/reset and DUT signals.
  logic            clk;
  logic            rst;
  logic            start;
  logic [KN-1:0]   h_in;
  logic [YW-1:0]   y;
  logic            busy;
  logic            done;
  logic            overflow;
`ifdef HINT_PACK_STREAM_EN
  logic [7:0]      byte_out;
  logic            byte_valid;
  logic            byte_ready;
`endif

  int n_checks;
  int n_fail;
  logic [YW:0] exp_q[$];

  hint_bit_pack #(.K(K), .N(N), .OMEGA(OMEGA)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .h_in       (h_in),
    .y          (y),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow)
`ifdef HINT_PACK_STREAM_EN
    ,
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [YW-1:0] got, input logic [YW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference encoder: {overflow, y}.
  function automatic logic [YW:0] model(input logic [KN-1:0] h);
    logic [YW-1:0] yy;
    int            cnt;
    logic          ov;
    yy  = '0;
    cnt = 0;
    ov  = 1'b0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < N; j++) begin
        if (h[i*N + j]) begin
          if (cnt < OMEGA) begin
            yy[cnt*8 +: 8] = 8'(j);
            cnt++;
          end else begin
            ov = 1'b1;
          end
        end
      end
      yy[(OMEGA + i)*8 +: 8] = 8'(cnt);
    end
    return {ov, yy};
  endfunction

  // Drive one packing job; optionally re-pulse start at scan cycle poke_cyc.
  task automatic run_pack(input logic [KN-1:0] h, input int poke_cyc);
    logic [YW:0] exp_v;
    int          cyc;
    bit          seen;
`ifdef HINT_PACK_STREAM_EN
    logic [YW-1:0] got_bytes;
    int            nb;
    bit            hold;
    logic [7:0]    held;
    got_bytes = '0;
    nb        = 0;
    hold      = 1'b0;
    held      = 8'd0;
`endif
    @(negedge clk);
    h_in  = h;
    start = 1'b1;
    exp_q.push_back(model(h));
    @(posedge clk);
    #1;
    start = 1'b0;
    h_in  = ~h;
    cyc   = 0;
    seen  = 1'b0;
    while (!seen && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      start = (cyc == poke_cyc);
      if (cyc == 1) check_eq("busy_after_start", YW'(busy), YW'(1'b1));
`ifdef HINT_PACK_STREAM_EN
      byte_ready = (cyc % 2 == 0);
      if (hold) begin
        check_eq("byte_stable", YW'(byte_out), YW'(held));
        hold = 1'b0;
      end
      if (byte_valid) begin
        if (byte_ready) begin
          if (nb < YB) got_bytes[nb*8 +: 8] = byte_out;
          nb++;
        end else begin
          hold = 1'b1;
          held = byte_out;
        end
      end
`endif
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    check_eq("done_seen", YW'(seen), YW'(1'b1));
    if (seen) begin
      exp_v = exp_q.pop_front();
`ifdef HINT_PACK_STREAM_EN
      check_eq("stream_count", YW'(nb), YW'(YB));
      check_eq("stream_bytes", got_bytes, exp_v[YW-1:0]);
`else
      check_eq("latency", YW'(cyc), YW'(LAT));
`endif
      check_eq("busy_in_done", YW'(busy), YW'(1'b0));
      check_eq("y", y, exp_v[YW-1:0]);
      check_eq("overflow", YW'(overflow), YW'(exp_v[YW]));
      @(negedge clk);
      check_eq("done_one_cycle", YW'(done), YW'(1'b0));
    end else begin
      exp_q.delete();
    end
  endtask

  initial begin
    logic [KN-1:0] hv;
    int            n_done;
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    start    = 1'b0;
    h_in     = '0;
`ifdef HINT_PACK_STREAM_EN
    byte_ready = 1'b0;
`endif

    // Reset state.
    repeat (3) @(negedge clk);
    check_eq("rst_y", y, '0);
    check_eq("rst_busy", YW'(busy), YW'(1'b0));
    check_eq("rst_done", YW'(done), YW'(1'b0));
    check_eq("rst_overflow", YW'(overflow), YW'(1'b0));
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // All-zero hints.
    run_pack('0, 0);

    // Two hints at the extremes of the matrix.
    hv = '0;
    hv[0*N + 5]   = 1'b1;
    hv[7*N + 255] = 1'b1;
    run_pack(hv, 0);
    check_eq("two_y1", YW'(y[1*8 +: 8]), YW'(8'd255));
    check_eq("two_y75", YW'(y[75*8 +: 8]), YW'(8'd1));
    check_eq("two_y82", YW'(y[82*8 +: 8]), YW'(8'd2));

    // Exactly OMEGA hints in polynomial 0.
    hv = '0;
    for (int j = 0; j < OMEGA; j++) hv[j] = 1'b1;
    run_pack(hv, 0);
    check_eq("full_y74", YW'(y[74*8 +: 8]), YW'(8'd74));
    check_eq("full_y75", YW'(y[75*8 +: 8]), YW'(8'd75));

    // One more hint: overflow, count saturates.
    hv[3*N + 0] = 1'b1;
    run_pack(hv, 0);
    check_eq("ovf_flag", YW'(overflow), YW'(1'b1));
    check_eq("ovf_y82", YW'(y[82*8 +: 8]), YW'(8'd75));

    // Start pulsed during the scan must be ignored.
    hv = '0;
    for (int t = 0; t < 30; t++) hv[$urandom_range(KN-1, 0)] = 1'b1;
    run_pack(hv, 100);

    // Random sparse and dense patterns.
    for (int r = 0; r < 3; r++) begin
      hv = '0;
      for (int t = 0; t < $urandom_range(70, 1); t++) hv[$urandom_range(KN-1, 0)] = 1'b1;
      run_pack(hv, 0);
    end
    hv = '0;
    for (int t = 0; t < 200; t++) hv[$urandom_range(KN-1, 0)] = 1'b1;
    run_pack(hv, 0);

    // Reset in the middle of a scan aborts with no done pulse.
    hv = '0;
    for (int t = 0; t < 40; t++) hv[$urandom_range(KN-1, 0)] = 1'b1;
    @(negedge clk);
    h_in  = hv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (500) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("abort_y", y, '0);
    check_eq("abort_busy", YW'(busy), YW'(1'b0));
    check_eq("abort_done", YW'(done), YW'(1'b0));
    check_eq("abort_overflow", YW'(overflow), YW'(1'b0));
    @(negedge clk);
    rst    = 1'b1;
    n_done = 0;
    repeat (2200) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check_eq("abort_no_done", YW'(n_done), YW'(0));
    run_pack(hv, 0);

    check_eq("queue_empty", YW'(exp_q.size()), YW'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
